// File: rtl/apb_cmd_master.sv
// APB4 initiator: turns a valid/ready command stream into single APB transfers
// and returns read data, slave error and a local timeout flag on a response channel.
module apb_cmd_master #(
  parameter type         addr_t         = logic [31:0],
  parameter type         data_t         = logic [31:0],
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                        pclk_i,
  input  logic                        preset_ni,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  addr_t                       cmd_addr_i,
  input  logic                        cmd_write_i,
  input  data_t                       cmd_wdata_i,
  input  logic [$bits(data_t)/8-1:0]  cmd_strb_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output data_t                       rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic                        rsp_timeout_o,
  output addr_t                       paddr_o,
  output data_t                       pwdata_o,
  output logic                        pwrite_o,
  output logic                        psel_o,
  output logic                        penable_o,
  output logic [$bits(data_t)/8-1:0]  pstrb_o,
  input  data_t                       prdata_i,
  input  logic                        pready_i,
  input  logic                        pslverr_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // A zero timeout would give a zero-width counter, so keep one bit that is never used.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;

  assign cmd_ready_o = preset_ni && (state == IDLE);
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && !pready_i && (wait_cnt == CNT_LAST);

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      paddr_o       <= '0;
      pwdata_o      <= '0;
      pwrite_o      <= 1'b0;
      pstrb_o       <= '0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            paddr_o  <= cmd_addr_i;
            pwrite_o <= cmd_write_i;
            pwdata_o <= cmd_wdata_i;
            pstrb_o  <= cmd_write_i ? cmd_strb_i : '0;
            psel_o   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          wait_cnt  <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          // A ready slave on the last allowed cycle still completes normally.
          if (pready_i) begin
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= pslverr_i;
            rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
            rsp_timeout_o <= 1'b0;
            state         <= RESP;
          end else if (timeout_hit) begin
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= 1'b1;
            rsp_rdata_o   <= '0;
            rsp_timeout_o <= 1'b1;
            state         <= RESP;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Randomized bench for apb_cmd_master: the bench plays the APB slave and predicts
// each response from the transfer rules (wait count, timeout limit, read/write).
module tb_apb_cmd_master;

  localparam int TMO = 4;

  logic        pclk;
  logic        preset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks;
  int failures;

  apb_cmd_master #(
    .addr_t(logic [31:0]),
    .data_t(logic [31:0]),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pclk_i(pclk),
    .preset_ni(preset_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr),
    .cmd_write_i(cmd_write),
    .cmd_wdata_i(cmd_wdata),
    .cmd_strb_i(cmd_strb),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .rsp_timeout_o(rsp_timeout),
    .paddr_o(paddr),
    .pwdata_o(pwdata),
    .pwrite_o(pwrite),
    .psel_o(psel),
    .penable_o(penable),
    .pstrb_o(pstrb),
    .prdata_i(prdata),
    .pready_i(pready),
    .pslverr_i(pslverr)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One full command/response round trip; expectations come from the transfer rules only.
  task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                               input logic [3:0] strb, input int waits, input logic slverr,
                               input logic [31:0] rdata, input int rsp_delay, input logic hold_valid);
    logic        timed_out;
    int          exp_access;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_strb;
    int          k;
    timed_out  = (waits >= TMO);
    exp_access = timed_out ? TMO : waits + 1;
    exp_err    = timed_out ? 1'b1 : slverr;
    exp_rdata  = (timed_out || wr) ? 32'h0 : rdata;
    exp_strb   = wr ? strb : 4'h0;

    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    tick();
    cmd_valid = hold_valid;
    checkOutput("setup_psel", 32'(psel), 32'd1);
    checkOutput("setup_penable", 32'(penable), 32'd0);
    checkOutput("setup_paddr", paddr, addr);
    checkOutput("setup_pwrite", 32'(pwrite), 32'(wr));
    checkOutput("setup_pwdata", pwdata, wdata);
    checkOutput("setup_pstrb", 32'(pstrb), 32'(exp_strb));
    checkOutput("busy_cmd_ready", 32'(cmd_ready), 32'd0);

    k = 0;
    for (int guard = 0; guard < 600; guard++) begin
      tick();
      if (!(psel && penable)) break;
      checkOutput("access_pstrb", 32'(pstrb), 32'(exp_strb));
      checkOutput("access_paddr", paddr, addr);
      pready  = (k == waits);
      pslverr = slverr;
      prdata  = rdata;
      k++;
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = $urandom;
    checkOutput("access_cycles", 32'(k), 32'(exp_access));
    checkOutput("rsp_valid_rise", 32'(rsp_valid), 32'd1);
    checkOutput("resp_psel", 32'(psel), 32'd0);
    checkOutput("resp_penable", 32'(penable), 32'd0);

    for (int i = 0; i < rsp_delay; i++) begin
      rsp_ready = 1'b0;
      cmd_valid = hold_valid;
      checkOutput("hold_rdata", rsp_rdata, exp_rdata);
      checkOutput("hold_err", 32'(rsp_err), 32'(exp_err));
      checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("hold_psel", 32'(psel), 32'd0);
      tick();
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
    end

    checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
    checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
    checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(timed_out));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    checkOutput("cmd_ready_back", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int gap;
    checks    = 0;
    failures  = 0;
    preset_n  = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;

    tick();
    tick();
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("reset_psel", 32'(psel), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_paddr", paddr, 32'd0);
    checkOutput("reset_pstrb", 32'(pstrb), 32'd0);
    preset_n = 1'b1;
    tick();

    $display("[TB] zero-wait write");
    applyStimulus(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'hCAFE0001, 0, 1'b0);
    $display("[TB] read with three wait states");
    applyStimulus(32'h20, 1'b0, 32'h0, 4'hF, 3, 1'b0, 32'h12345678, 0, 1'b0);
    $display("[TB] slave error on write");
    applyStimulus(32'h30, 1'b1, 32'h55AA55AA, 4'h3, 1, 1'b1, 32'h0, 0, 1'b0);
    $display("[TB] timeout on read");
    applyStimulus(32'h40, 1'b0, 32'h0, 4'hF, 50, 1'b0, 32'h87654321, 0, 1'b0);
    $display("[TB] response backpressure with queued command");
    applyStimulus(32'h50, 1'b0, 32'h0, 4'h1, 0, 1'b0, 32'hA5A5A5A5, 5, 1'b1);
    applyStimulus(32'h54, 1'b1, 32'h01020304, 4'hC, 0, 1'b0, 32'hFFFFFFFF, 0, 1'b0);

    $display("[TB] randomized transfers");
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cmd_valid = 1'b0;
        tick();
        checkOutput("gap_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("gap_psel", 32'(psel), 32'd0);
      end
      applyStimulus($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset during waited access");
    cmd_valid = 1'b1;
    cmd_addr  = 32'h60;
    cmd_write = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checkOutput("pre_reset_penable", 32'(penable), 32'd1);
    #2;
    preset_n = 1'b0;
    #1;
    checkOutput("async_psel", 32'(psel), 32'd0);
    checkOutput("async_penable", 32'(penable), 32'd0);
    checkOutput("async_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    preset_n = 1'b1;
    tick();
    checkOutput("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    checkOutput("post_reset_psel", 32'(psel), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
